ahb_bus_arbiter: RTL and testbench

//  AHB multi-master bus arbiter. Sits between N AHB masters (hbusreq/hlock/hgrant) and the shared bus.

---
 rtl/ahb_bus_arbiter_if.sv | 26 ++
 rtl/ahb_bus_arbiter.sv | 94 +++++++++
 tb/tb_ahb_bus_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bus_arbiter_if.sv
// Signal bundle between the AHB masters' request/transfer lines and the bus arbiter.
// The arbiter connects through the slave modport; the master modport is the requesting side.
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4
);
   localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic [1:0]             htrans;
   logic [2:0]             hburst;
   logic                   hready;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [MW-1:0]          hmaster;
   logic                   hmastlock;

   modport master (
      output hbusreq, hlock, htrans, hburst, hready,
      input  hgrant, hmaster, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready,
      output hgrant, hmaster, hmastlock
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// AHB round-robin bus arbiter: keeps fixed bursts and locked sequences intact,
// parks on DEFAULT_MASTER when idle, drives registered hgrant/hmaster/hmastlock.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic             hclk,
   input  logic             hreset,
   ahb_bus_arbiter_if.slave bus
);
   localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_e;

   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [MW-1:0]          master_q;
   logic                   mastlock_q;
   logic [4:0]             beats_q, beats_d;
   logic [MW-1:0]          g, sel, cand;
   logic                   found, arb_ok;

   always_comb begin
      g = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) g = MW'(i);
      end
   end

   // Remaining address beats of the current fixed-length burst
   always_comb begin
      beats_d = beats_q;
      case (htrans_e'(bus.htrans))
         IDLE:   beats_d = '0;
         BUSY:   beats_d = beats_q;
         NONSEQ: begin
            case (bus.hburst)
               3'd2, 3'd3: beats_d = 5'd3;
               3'd4, 3'd5: beats_d = 5'd7;
               3'd6, 3'd7: beats_d = 5'd15;
               default:    beats_d = '0;
            endcase
         end
         SEQ:     beats_d = (beats_q != '0) ? beats_q - 5'd1 : '0;
         default: beats_d = beats_q;
      endcase
   end

   assign arb_ok = bus.hready && (beats_d == '0) && (bus.htrans != BUSY)
                   && !bus.hlock[g] && !mastlock_q;

   // Round-robin search starting after the current owner; owner is checked last
   always_comb begin
      sel   = DEF_IDX;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         cand = MW'((32'(g) + i) % NUM_MASTERS);
         if (!found && bus.hbusreq[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
      grant_d = grant_q;
      if (arb_ok) begin
         grant_d      = '0;
         grant_d[sel] = 1'b1;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         grant_q    <= GRANT_RST;
         master_q   <= DEF_IDX;
         mastlock_q <= 1'b0;
         beats_q    <= '0;
      end else if (bus.hready) begin
         grant_q    <= grant_d;
         master_q   <= g;
         mastlock_q <= bus.hlock[g];
         beats_q    <= beats_d;
      end
   end

   assign bus.hgrant    = grant_q;
   assign bus.hmaster   = master_q;
   assign bus.hmastlock = mastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: vector table, directed burst/lock/reset
// sequences, and randomized traffic against a behavioural reference model.
module tb_ahb_bus_arbiter;
   localparam int N = 4;

   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

   logic hclk = 1'b0;
   logic hreset;

   ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

   ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus.slave)
   );

   always #5 hclk = ~hclk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: owner index, address-phase master, lock flag, beats left
   int m_g, m_m, m_r;
   bit m_lk;

   typedef struct {
      logic [3:0] req;
      logic [3:0] lock;
      logic [1:0] trans;
      logic [2:0] burst;
      logic       ready;
      logic [3:0] eg;
      logic [1:0] em;
      logic       el;
   } vec_t;

   vec_t tbl[7];

   function automatic int fixed_len(logic [2:0] b);
      int bi = int'(b);
      return (bi < 2) ? 0 : (2 << (bi / 2));
   endfunction

   task automatic model_reset();
      m_g = 0; m_m = 0; m_lk = 0; m_r = 0;
   endtask

   task automatic model_edge(logic [3:0] req, logic [3:0] lock, logic [1:0] trans,
                             logic [2:0] burst, logic ready);
      int nr;
      bit arb;
      if (!ready) return;
      case (trans)
         T_IDLE:  nr = 0;
         T_NSEQ:  nr = (fixed_len(burst) > 0) ? fixed_len(burst) - 1 : 0;
         T_SEQ:   nr = (m_r > 0) ? m_r - 1 : 0;
         default: nr = m_r;
      endcase
      arb  = (nr == 0) && (trans != T_BUSY) && !lock[m_g] && !m_lk;
      m_m  = m_g;
      m_lk = lock[m_g];
      m_r  = nr;
      if (arb) begin
         int nxt = 0;
         for (int k = 1; k <= N; k++) begin
            if (req[(m_g + k) % N]) begin
               nxt = (m_g + k) % N;
               break;
            end
         end
         m_g = nxt;
      end
   endtask

   task automatic drive(logic [3:0] req, logic [3:0] lock, logic [1:0] trans,
                        logic [2:0] burst, logic ready);
      bus.hbusreq = req;
      bus.hlock   = lock;
      bus.htrans  = trans;
      bus.hburst  = burst;
      bus.hready  = ready;
      @(posedge hclk);
      model_edge(req, lock, trans, burst, ready);
      #1;
   endtask

   task automatic check(string name, logic [3:0] eg, logic [1:0] em, logic el);
      n_vec++;
      if (bus.hgrant !== eg || bus.hmaster !== em || bus.hmastlock !== el) begin
         n_err++;
         $display("FAIL %s: got hgrant=%b hmaster=%0d hmastlock=%b, expected hgrant=%b hmaster=%0d hmastlock=%b",
                  name, bus.hgrant, bus.hmaster, bus.hmastlock, eg, em, el);
      end
   endtask

   task automatic check_model(string name);
      check(name, 4'(1 << m_g), 2'(m_m), m_lk);
   endtask

   task automatic do_reset();
      hreset = 1'b1;
      model_reset();
      @(posedge hclk);
      #1;
      hreset = 1'b0;
   endtask

   task automatic burst4_seq(bit busy_stall);
      string p = busy_stall ? "incr4_stall" : "incr4";
      do_reset();
      drive(4'b0010, 4'b0, T_IDLE, 3'd0, 1'b1); check({p, "_grant_m1"}, 4'b0010, 2'd0, 1'b0);
      drive(4'b0010, 4'b0, T_IDLE, 3'd0, 1'b1); check({p, "_own_m1"},   4'b0010, 2'd1, 1'b0);
      drive(4'b0110, 4'b0, T_NSEQ, 3'd3, 1'b1); check({p, "_beat1"},    4'b0010, 2'd1, 1'b0);
      drive(4'b0110, 4'b0, T_SEQ,  3'd3, 1'b1); check({p, "_beat2"},    4'b0010, 2'd1, 1'b0);
      if (busy_stall) begin
         drive(4'b0110, 4'b0, T_BUSY, 3'd3, 1'b1); check({p, "_busy"}, 4'b0010, 2'd1, 1'b0);
         for (int s = 0; s < 3; s++) begin
            drive(4'b0110, 4'b0, T_SEQ, 3'd3, 1'b0);
            check($sformatf("%s_stall%0d", p, s), 4'b0010, 2'd1, 1'b0);
         end
      end
      drive(4'b0110, 4'b0, T_SEQ,  3'd3, 1'b1); check({p, "_beat3"},    4'b0010, 2'd1, 1'b0);
      drive(4'b0110, 4'b0, T_SEQ,  3'd3, 1'b1); check({p, "_beat4"},    4'b0100, 2'd1, 1'b0);
      drive(4'b0100, 4'b0, T_IDLE, 3'd0, 1'b1); check({p, "_own_m2"},   4'b0100, 2'd2, 1'b0);
   endtask

   initial begin
      bus.hbusreq = '0; bus.hlock = '0; bus.htrans = T_IDLE; bus.hburst = '0; bus.hready = 1'b1;
      hreset = 1'b1;
      model_reset();

      //                 req      lock    trans   burst ready  eg       em    el
      tbl[0] = '{4'b0110, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 1'b0};
      tbl[1] = '{4'b0110, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0};
      tbl[2] = '{4'b0110, 4'b0000, T_NSEQ, 3'd0, 1'b1, 4'b0010, 2'd2, 1'b0};
      tbl[3] = '{4'b0110, 4'b0000, T_NSEQ, 3'd0, 1'b1, 4'b0100, 2'd1, 1'b0};
      tbl[4] = '{4'b0000, 4'b0000, T_NSEQ, 3'd0, 1'b1, 4'b0001, 2'd2, 1'b0};
      tbl[5] = '{4'b0000, 4'b0000, T_IDLE, 3'd0, 1'b0, 4'b0001, 2'd2, 1'b0};
      tbl[6] = '{4'b0000, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0001, 2'd0, 1'b0};

      #1;
      check("reset_async", 4'b0001, 2'd0, 1'b0);
      do_reset();
      check("reset", 4'b0001, 2'd0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         drive(4'b0000, 4'b0000, T_IDLE, 3'd0, 1'b1);
         check($sformatf("park_%0d", c), 4'b0001, 2'd0, 1'b0);
      end

      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].ready);
         check($sformatf("table_%0d", i), tbl[i].eg, tbl[i].em, tbl[i].el);
      end

      burst4_seq(1'b0);
      burst4_seq(1'b1);

      // Locked INCR8 from M0 with M3 waiting
      do_reset();
      drive(4'b1001, 4'b0001, T_IDLE, 3'd0, 1'b1); check("lock_start", 4'b0001, 2'd0, 1'b1);
      drive(4'b1001, 4'b0001, T_NSEQ, 3'd5, 1'b1); check("lock_beat1", 4'b0001, 2'd0, 1'b1);
      for (int b = 2; b <= 8; b++) begin
         drive(4'b1001, 4'b0001, T_SEQ, 3'd5, 1'b1);
         check($sformatf("lock_beat%0d", b), 4'b0001, 2'd0, 1'b1);
      end
      drive(4'b1001, 4'b0000, T_NSEQ, 3'd0, 1'b1); check("lock_tail",   4'b0001, 2'd0, 1'b0);
      drive(4'b1001, 4'b0000, T_IDLE, 3'd0, 1'b1); check("lock_handov", 4'b1000, 2'd0, 1'b0);
      drive(4'b1000, 4'b0000, T_IDLE, 3'd0, 1'b1); check("lock_own_m3", 4'b1000, 2'd3, 1'b0);

      // Asynchronous reset in the middle of an INCR16 owned by M1
      do_reset();
      drive(4'b0010, 4'b0, T_IDLE, 3'd0, 1'b1);
      drive(4'b0010, 4'b0, T_IDLE, 3'd0, 1'b1); check("r16_own_m1", 4'b0010, 2'd1, 1'b0);
      drive(4'b0110, 4'b0, T_NSEQ, 3'd7, 1'b1);
      for (int b = 2; b <= 5; b++) drive(4'b0110, 4'b0, T_SEQ, 3'd7, 1'b1);
      check("r16_beat5", 4'b0010, 2'd1, 1'b0);
      #2 hreset = 1'b1;
      model_reset();
      #1 check("r16_async_reset", 4'b0001, 2'd0, 1'b0);
      #2 hreset = 1'b0;
      drive(4'b0010, 4'b0, T_SEQ, 3'd0, 1'b1); check("r16_after_reset", 4'b0010, 2'd0, 1'b0);

      // Randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [3:0] lk;
         for (int b = 0; b < N; b++) lk[b] = ($urandom_range(0, 5) == 0);
         drive(4'($urandom), lk, 2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
         check_model($sformatf("rand_%0d", c));
         if ($urandom_range(0, 59) == 0) begin
            #2 hreset = 1'b1;
            model_reset();
            #1 check_model($sformatf("rand_reset_%0d", c));
            #2 hreset = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
